// File: rtl/tile_pkg.sv
// Shared types and default geometry for the tile pixel streamer.
package tile_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_RAM,
      ST_RD_ROM,
      ST_LOAD,
      ST_HOLD
   } fetch_state_e;

   localparam int unsigned DEF_RAM_DATA_WIDTH = 7;
   localparam int unsigned DEF_RAM_ADDR_WIDTH = 9;
   localparam int unsigned DEF_ROM_ADDR_WIDTH = 12;
   localparam int unsigned DEF_TILES_PER_ROW  = 20;
   localparam int unsigned DEF_TILES_PER_COL  = 15;
   localparam int unsigned DEF_TILE_W         = 32;
   localparam int unsigned DEF_TILE_H         = 32;
   localparam int unsigned DEF_BPP            = 3;

   // Counter width for a modulo-n counter, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_row_serializer.sv
// Prefetch buffer plus shift register turning tile rows into a pixel stream.
module tile_row_serializer
   import tile_pkg::*;
#(
   parameter  int unsigned TILE_W   = DEF_TILE_W,
   parameter  int unsigned BPP      = DEF_BPP,
   localparam int unsigned ROW_BITS = TILE_W * BPP
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                load_i,
   input  logic [ROW_BITS-1:0] load_data_i,
   input  logic                pix_ready_i,
   output logic [BPP-1:0]      pix_data_o,
   output logic                pix_valid_o,
   output logic                buf_full_o,
   output logic                sh_free_c,
   output logic                last_xfer_c
);

   localparam int unsigned CNT_W = cnt_width(TILE_W);

   logic [ROW_BITS-1:0] buf_q;
   logic [ROW_BITS-1:0] sh_q;
   logic                buf_full_q;
   logic                sh_valid_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                xfer_c;

   assign xfer_c      = sh_valid_q && pix_ready_i;
   assign last_xfer_c = xfer_c && (cnt_q == CNT_W'(TILE_W - 1));
   assign sh_free_c   = !sh_valid_q || last_xfer_c;

   assign pix_data_o  = sh_q[ROW_BITS-1 -: BPP];
   assign pix_valid_o = sh_valid_q;
   assign buf_full_o  = buf_full_q;

   // A freed shifter takes the buffered row first, else a fresh load bypasses the buffer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q      <= '0;
         sh_q       <= '0;
         buf_full_q <= 1'b0;
         sh_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else if (sh_free_c) begin
         if (buf_full_q) begin
            sh_q       <= buf_q;
            sh_valid_q <= 1'b1;
            cnt_q      <= '0;
            buf_full_q <= load_i;
            if (load_i) begin
               buf_q <= load_data_i;
            end
         end else if (load_i) begin
            sh_q       <= load_data_i;
            sh_valid_q <= 1'b1;
            cnt_q      <= '0;
         end else begin
            sh_valid_q <= 1'b0;
         end
      end else begin
         if (xfer_c) begin
            sh_q  <= sh_q << BPP;
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (load_i) begin
            buf_q      <= load_data_i;
            buf_full_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_pixel_streamer.sv
// Walks the tile map line by line, fetches tile rows from the pixel ROM and streams pixels.
module tile_pixel_streamer
   import tile_pkg::*;
#(
   parameter  int unsigned RAM_DATA_WIDTH = DEF_RAM_DATA_WIDTH,
   parameter  int unsigned RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
   parameter  int unsigned ROM_ADDR_WIDTH = DEF_ROM_ADDR_WIDTH,
   parameter  int unsigned TILES_PER_ROW  = DEF_TILES_PER_ROW,
   parameter  int unsigned TILES_PER_COL  = DEF_TILES_PER_COL,
   parameter  int unsigned TILE_W         = DEF_TILE_W,
   parameter  int unsigned TILE_H         = DEF_TILE_H,
   parameter  int unsigned BPP            = DEF_BPP,
   localparam int unsigned ROM_DATA_WIDTH = TILE_W * BPP
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   input  logic [RAM_DATA_WIDTH-1:0] ram_data_i,
   output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [ROM_DATA_WIDTH-1:0] rom_data_i,
   output logic [BPP-1:0]            pix_data_o,
   output logic                      pix_valid_o,
   input  logic                      pix_ready_i,
   output logic                      busy_o,
   output logic                      frame_done_o
);

   localparam int unsigned COL_W  = cnt_width(TILES_PER_ROW);
   localparam int unsigned ROW_W  = cnt_width(TILE_H);
   localparam int unsigned TROW_W = cnt_width(TILES_PER_COL);

   fetch_state_e              state_q, state_d;
   logic [COL_W-1:0]          col_q, col_d;
   logic [ROW_W-1:0]          row_q, row_d;
   logic [TROW_W-1:0]         trow_q, trow_d;
   logic [RAM_ADDR_WIDTH-1:0] base_q, base_d;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
   logic                      last_q, last_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic load_c;
   logic start_c;
   logic col_end_c, row_end_c, trow_end_c;
   logic buf_full;
   logic sh_free_c;
   logic last_xfer_c;

   assign start_c    = start_i && !busy_q && !done_q;
   assign col_end_c  = (col_q == COL_W'(TILES_PER_ROW - 1));
   assign row_end_c  = (row_q == ROW_W'(TILE_H - 1));
   assign trow_end_c = (trow_q == TROW_W'(TILES_PER_COL - 1));

   // ram_addr_o always points at the next tile to fetch, so RD_RAM sees its data.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      trow_d     = trow_q;
      base_d     = base_q;
      ram_addr_d = ram_addr_q;
      rom_addr_d = rom_addr_q;
      last_d     = last_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      load_c     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               state_d = ST_RD_RAM;
               busy_d  = 1'b1;
            end
         end
         ST_RD_RAM: begin
            state_d    = ST_RD_ROM;
            rom_addr_d = ROM_ADDR_WIDTH'(32'(ram_data_i) * TILE_H + 32'(row_q));
         end
         ST_RD_ROM: begin
            state_d = ST_LOAD;
            last_d  = col_end_c && row_end_c && trow_end_c;
            if (!col_end_c) begin
               col_d = col_q + COL_W'(1);
            end else begin
               col_d = '0;
               if (!row_end_c) begin
                  row_d = row_q + ROW_W'(1);
               end else begin
                  row_d = '0;
                  if (trow_end_c) begin
                     trow_d = '0;
                     base_d = '0;
                  end else begin
                     trow_d = trow_q + TROW_W'(1);
                     base_d = base_q + RAM_ADDR_WIDTH'(TILES_PER_ROW);
                  end
               end
            end
            ram_addr_d = base_d + RAM_ADDR_WIDTH'(col_d);
         end
         ST_LOAD: begin
            load_c = 1'b1;
            if (last_q) begin
               state_d = ST_IDLE;
               last_d  = 1'b0;
            end else if (!buf_full && sh_free_c) begin
               state_d = ST_RD_RAM;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!buf_full || sh_free_c) begin
               state_d = ST_RD_RAM;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Fetching is over once back in IDLE while busy; the frame ends with the final pixel.
      if (busy_q && (state_q == ST_IDLE) && last_xfer_c && !buf_full) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         trow_q     <= '0;
         base_q     <= '0;
         ram_addr_q <= '0;
         rom_addr_q <= '0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         trow_q     <= trow_d;
         base_q     <= base_d;
         ram_addr_q <= ram_addr_d;
         rom_addr_q <= rom_addr_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ram_addr_o   = ram_addr_q;
   assign rom_addr_o   = rom_addr_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;

   tile_row_serializer #(
      .TILE_W (TILE_W),
      .BPP    (BPP)
   ) u_ser (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .load_i      (load_c),
      .load_data_i (rom_data_i),
      .pix_ready_i (pix_ready_i),
      .pix_data_o  (pix_data_o),
      .pix_valid_o (pix_valid_o),
      .buf_full_o  (buf_full),
      .sh_free_c   (sh_free_c),
      .last_xfer_c (last_xfer_c)
   );

endmodule

// File: tb/tb_tile_pixel_streamer.sv
// Scoreboard bench for tile_pixel_streamer on a reduced screen geometry.
module tb_tile_pixel_streamer;

   localparam int RDW   = 7;
   localparam int RAW   = 9;
   localparam int ROMAW = 8;
   localparam int TPR   = 4;
   localparam int TPC   = 3;
   localparam int TW    = 8;
   localparam int TH    = 4;
   localparam int BPP   = 3;
   localparam int ROWB  = TW * BPP;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            ready;
   logic            valid;
   logic            busy;
   logic            done;
   logic [RAW-1:0]  ram_addr;
   logic [RDW-1:0]  ram_data;
   logic [ROMAW-1:0] rom_addr;
   logic [ROWB-1:0] rom_data;
   logic [BPP-1:0]  pix;

   logic [RDW-1:0]  tmap [1 << RAW];
   logic [ROWB-1:0] rom  [1 << ROMAW];
   logic [BPP-1:0]  exp_q [$];

   int total = 0;
   int bad = 0;
   int pix_count = 0;
   bit stall_q = 1'b0;

   always #5 clk = ~clk;

   tile_pixel_streamer #(
      .RAM_DATA_WIDTH (RDW),
      .RAM_ADDR_WIDTH (RAW),
      .ROM_ADDR_WIDTH (ROMAW),
      .TILES_PER_ROW  (TPR),
      .TILES_PER_COL  (TPC),
      .TILE_W         (TW),
      .TILE_H         (TH),
      .BPP            (BPP)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .ram_addr_o   (ram_addr),
      .ram_data_i   (ram_data),
      .rom_addr_o   (rom_addr),
      .rom_data_i   (rom_data),
      .pix_data_o   (pix),
      .pix_valid_o  (valid),
      .pix_ready_i  (ready),
      .busy_o       (busy),
      .frame_done_o (done)
   );

   // Synchronous memories with one cycle of read latency.
   always @(posedge clk) begin
      ram_data <= tmap[ram_addr];
      rom_data <= rom[rom_addr];
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference frame: every screen line, every tile column, pixels left to right.
   task automatic push_frame();
      int t;
      int a;
      logic [ROWB-1:0] r;
      for (int l = 0; l < TPC * TH; l++) begin
         for (int c = 0; c < TPR; c++) begin
            t = int'(tmap[(l / TH) * TPR + c]);
            a = (t * TH + l % TH) % (1 << ROMAW);
            r = rom[a];
            for (int p = 0; p < TW; p++) begin
               exp_q.push_back(BPP'(r >> (ROWB - (p + 1) * BPP)));
            end
         end
      end
   endtask

   // Pixel monitor: pops the scoreboard on every transfer, checks holds during stalls.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("hold_valid", int'(valid), 1);
         end
         if (valid && !ready && exp_q.size() > 0) begin
            chk("stall_data", int'(pix), int'(exp_q[0]));
         end
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_pixel: got pixel %0d with none expected", pix);
            end else begin
               chk("pixel", int'(pix), int'(exp_q.pop_front()));
               pix_count++;
            end
         end
         stall_q = valid && !ready;
      end
   end

   task automatic start_frame(input int exp_rom);
      push_frame();
      @(posedge clk); #1;
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_busy", int'(busy), 1);
      chk("start_ram_addr", int'(ram_addr), 0);
      @(negedge clk);
      chk("first_rom_addr", int'(rom_addr), exp_rom);
      @(negedge clk);
      chk("latency_not_early", int'(valid), 0);
      @(negedge clk);
      chk("latency_4", int'(valid), 1);
   endtask

   // mode 0: ready held high, start held through the frame end; mode 1: random ready.
   task automatic run_frame(input int mode, output int gaps);
      bit seen = 1'b0;
      bit got = 1'b0;
      gaps = 0;
      for (int k = 0; k < 5000 && !got; k++) begin
         @(posedge clk); #1;
         if (mode == 0) begin
            ready = 1'b1;
            start = (exp_q.size() <= 3);
         end else begin
            ready = (k >= 60 && k < 70) ? 1'b0 : ($urandom_range(0, 99) < 70);
            start = (k == 200);
         end
         @(negedge clk);
         if (valid) seen = 1'b1;
         if (seen && busy && !valid) gaps++;
         if (done) got = 1'b1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL frame_done_timeout: no frame_done within 5000 cycles, %0d pixels left", exp_q.size());
      end else begin
         chk("done_busy_low", int'(busy), 0);
         chk("done_valid_low", int'(valid), 0);
         chk("done_all_pixels", exp_q.size(), 0);
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         chk("done_single_pulse", int'(done), 0);
         chk("start_in_done_ignored", int'(busy), 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int gaps;
      int seen_done;
      int k;
      rst_n = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      foreach (rom[i]) rom[i] = ROWB'($urandom);
      foreach (tmap[i]) tmap[i] = RDW'(5);

      repeat (3) @(negedge clk);
      chk("rst_valid", int'(valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pix", int'(pix), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Uniform tile type 5, continuous ready.
      start_frame(5 * TH);
      run_frame(0, gaps);
      chk("gap_free", gaps, 0);

      // Random tile map including both extreme tile types, random back-pressure.
      foreach (tmap[i]) tmap[i] = RDW'($urandom_range(0, 127));
      tmap[1] = RDW'(0);
      tmap[2] = RDW'(127);
      start_frame((int'(tmap[0]) * TH) % (1 << ROMAW));
      run_frame(1, gaps);

      // Tile type 127 overflows the ROM address; abandon the frame by reset.
      foreach (tmap[i]) tmap[i] = RDW'(127);
      pix_count = 0;
      start_frame((127 * TH) % (1 << ROMAW));
      k = 0;
      while (pix_count < 100 && k < 2000) begin
         @(posedge clk); #1;
         ready = ($urandom_range(0, 99) < 80);
         k++;
      end
      if (pix_count < 100) begin
         total++;
         bad++;
         $display("FAIL reach_pixel_100: only %0d pixels after 2000 cycles", pix_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_pix", int'(pix), 0);
      chk("midrst_ram_addr", int'(ram_addr), 0);
      chk("midrst_rom_addr", int'(rom_addr), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen_done = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      chk("no_done_after_reset", seen_done, 0);

      // Fresh frame after reset must begin at tile 0, line 0.
      foreach (tmap[i]) tmap[i] = RDW'($urandom_range(0, 127));
      start_frame((int'(tmap[0]) * TH) % (1 << ROMAW));
      run_frame(1, gaps);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
